// File: rtl/layer_pkg.sv
// rtl/layer_pkg.sv - shared types, limits and colour expansion for the layer compositor
package layer_pkg;

  localparam int MAX_LAYERS = 16;

  // 8-bit packed colour: RRR GGG BB
  typedef logic [7:0] rgb332_t;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb888_t;

  // Widen each channel by replicating its least-significant bit so that
  // full-scale inputs map to 0xFF and zero maps to 0x00.
  function automatic rgb888_t expand_rgb332(input rgb332_t c);
    rgb888_t e;
    e.red   = {c[7:5], {5{c[5]}}};
    e.green = {c[4:2], {5{c[2]}}};
    e.blue  = {c[1:0], {6{c[0]}}};
    return e;
  endfunction

endpackage

// File: rtl/layer_priority_enc.sv
// rtl/layer_priority_enc.sv - lowest-index-wins priority encoder over layer requests
module layer_priority_enc #(
  parameter int NUM_LAYERS = 8,
  parameter int IDX_W      = $clog2(NUM_LAYERS)
) (
  input  logic [NUM_LAYERS-1:0] req_i,
  output logic [IDX_W-1:0]      idx_o,
  output logic                  valid_o
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = IDX_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/layer_compositor.sv
// rtl/layer_compositor.sv - prioritised layer mixer with frame-synchronous config, blink and optional collision detect (LAYER_COLLISION_DETECT_EN)
module layer_compositor
  import layer_pkg::*;
#(
  parameter int NUM_LAYERS = 8,
  parameter int BLINK_LOG2 = 4
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic                          startOfFrame,
  input  logic [NUM_LAYERS-1:0]         layerDrawReq,
  input  rgb332_t [NUM_LAYERS-1:0]      layerRGB,
  input  rgb332_t                       backGroundRGB,
  input  logic                          cfgValid,
  output logic                          cfgReady,
  input  logic [$clog2(NUM_LAYERS)-1:0] cfgLayer,
  input  logic                          cfgEnable,
  input  logic                          cfgBlink,
  output logic [7:0]                    redOut,
  output logic [7:0]                    greenOut,
  output logic [7:0]                    blueOut,
  output logic [NUM_LAYERS-1:0]         collisionMask,
  output logic                          collisionFlag
);

  localparam int IDX_W = $clog2(NUM_LAYERS);

  if (NUM_LAYERS < 2 || NUM_LAYERS > MAX_LAYERS) begin : g_bad_num_layers
    $error("layer_compositor: NUM_LAYERS out of range");
  end
  if (BLINK_LOG2 < 1 || BLINK_LOG2 > 7) begin : g_bad_blink_log2
    $error("layer_compositor: BLINK_LOG2 out of range");
  end

  logic [NUM_LAYERS-1:0] shadow_en_q, shadow_en_d;
  logic [NUM_LAYERS-1:0] shadow_blink_q, shadow_blink_d;
  logic [NUM_LAYERS-1:0] active_en_q, active_blink_q;
  logic [BLINK_LOG2-1:0] frame_cnt_q;
  logic                  blink_phase_q;
  logic [NUM_LAYERS-1:0] eff_req;
  logic [IDX_W-1:0]      sel_idx;
  logic                  sel_valid;
  rgb332_t               pix_d, pix_q;
  rgb888_t               out_q;
  logic                  cfg_fire;

  // Config is held off only during the frame-start cycle, when shadow state
  // is being transferred to the active set.
  assign cfgReady = ~startOfFrame;
  assign cfg_fire = cfgValid & cfgReady;

  // Shadow update; an index with no matching layer simply writes nothing.
  always_comb begin
    shadow_en_d    = shadow_en_q;
    shadow_blink_d = shadow_blink_q;
    if (cfg_fire) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (cfgLayer == IDX_W'(i)) begin
          shadow_en_d[i]    = cfgEnable;
          shadow_blink_d[i] = cfgBlink;
        end
      end
    end
  end

  // Shadow registers accept writes at any time in the frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      shadow_en_q    <= '1;
      shadow_blink_q <= '0;
    end else begin
      shadow_en_q    <= shadow_en_d;
      shadow_blink_q <= shadow_blink_d;
    end
  end

  // Active state only changes at frame start, so a frame is never torn.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      active_en_q    <= '1;
      active_blink_q <= '0;
    end else if (startOfFrame) begin
      active_en_q    <= shadow_en_q;
      active_blink_q <= shadow_blink_q;
    end
  end

  // Frame counter; the blink phase flips each time it wraps.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (startOfFrame) begin
      frame_cnt_q <= frame_cnt_q + BLINK_LOG2'(1);
      if (&frame_cnt_q) begin
        blink_phase_q <= ~blink_phase_q;
      end
    end
  end

  assign eff_req = layerDrawReq & active_en_q
                 & ~(active_blink_q & {NUM_LAYERS{blink_phase_q}});

  layer_priority_enc #(
    .NUM_LAYERS (NUM_LAYERS),
    .IDX_W      (IDX_W)
  ) u_prio (
    .req_i   (eff_req),
    .idx_o   (sel_idx),
    .valid_o (sel_valid)
  );

  assign pix_d = sel_valid ? layerRGB[sel_idx] : backGroundRGB;

  // Two-stage colour pipeline: select, then expand to 24 bits.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pix_q <= '0;
      out_q <= '0;
    end else begin
      pix_q <= pix_d;
      out_q <= expand_rgb332(pix_q);
    end
  end

  assign redOut   = out_q.red;
  assign greenOut = out_q.green;
  assign blueOut  = out_q.blue;

`ifdef LAYER_COLLISION_DETECT_EN
  logic [NUM_LAYERS-1:0] coll_acc_q;
  logic [NUM_LAYERS-1:0] coll_mask_q;
  logic [NUM_LAYERS-1:0] coll_hit;
  logic                  multi_req;

  // More than one bit set: clearing the lowest set bit leaves something.
  assign multi_req = |(eff_req & (eff_req - NUM_LAYERS'(1)));
  assign coll_hit  = eff_req & {NUM_LAYERS{multi_req}};

  // Sticky per-frame overlap accumulator, published at frame start.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      coll_acc_q  <= '0;
      coll_mask_q <= '0;
    end else if (startOfFrame) begin
      coll_mask_q <= coll_acc_q | coll_hit;
      coll_acc_q  <= '0;
    end else begin
      coll_acc_q  <= coll_acc_q | coll_hit;
    end
  end

  assign collisionMask = coll_mask_q;
  assign collisionFlag = |coll_mask_q;
`else
  assign collisionMask = '0;
  assign collisionFlag = 1'b0;
`endif

endmodule

// File: tb/tb_layer_compositor.sv
// tb/tb_layer_compositor.sv - directed self-checking bench for layer_compositor
module tb_layer_compositor;

  localparam int NL = 6;

  logic            clk;
  logic            resetN;
  logic            sof;
  logic [NL-1:0]   req;
  logic [NL-1:0][7:0] rgb;
  logic [7:0]      bg;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [2:0]      cfg_layer;
  logic            cfg_en;
  logic            cfg_blink;
  logic [7:0]      red_o, green_o, blue_o;
  logic [NL-1:0]   coll_mask;
  logic            coll_flag;

  int n_cmp = 0;
  int n_bad = 0;
  logic vis;

  layer_compositor #(
    .NUM_LAYERS (NL),
    .BLINK_LOG2 (1)
  ) dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (sof),
    .layerDrawReq  (req),
    .layerRGB      (rgb),
    .backGroundRGB (bg),
    .cfgValid      (cfg_valid),
    .cfgReady      (cfg_ready),
    .cfgLayer      (cfg_layer),
    .cfgEnable     (cfg_en),
    .cfgBlink      (cfg_blink),
    .redOut        (red_o),
    .greenOut      (green_o),
    .blueOut       (blue_o),
    .collisionMask (coll_mask),
    .collisionFlag (coll_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_sof();
    sof = 1'b1;
    tick();
    sof = 1'b0;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    tick();
  endtask

  initial begin
    resetN    = 1'b0;
    sof       = 1'b0;
    req       = '0;
    rgb       = '0;
    bg        = 8'h00;
    cfg_valid = 1'b0;
    cfg_layer = '0;
    cfg_en    = 1'b1;
    cfg_blink = 1'b0;
    rgb[0]    = 8'hE0;
    rgb[1]    = 8'h03;
    rgb[2]    = 8'h1C;
    rgb[3]    = 8'h1C;

    // reset state
    repeat (2) tick();
    check("rst_red", red_o, 0);
    check("rst_green", green_o, 0);
    check("rst_blue", blue_o, 0);
    check("rst_mask", coll_mask, 0);
    check("rst_flag", coll_flag, 0);
    check("rst_ready", cfg_ready, 1);
    resetN = 1'b1;
    tick();

    // layers 0 and 3 request, layer 0 wins
    req = 6'b001001;
    tick();
    tick();
    check("prio_red", red_o, 8'hFF);
    check("prio_green", green_o, 8'h00);
    check("prio_blue", blue_o, 8'h00);

    // background and exact two-cycle latency
    req = '0;
    bg  = 8'h00;
    tick();
    tick();
    bg = 8'h03;
    tick();
    check("lat1_blue", blue_o, 8'h00);
    bg = 8'hE0;
    tick();
    check("bg_red", red_o, 8'h00);
    check("bg_green", green_o, 8'h00);
    check("bg_blue", blue_o, 8'hFF);
    tick();
    check("lat3_red", red_o, 8'hFF);
    check("lat3_blue", blue_o, 8'h00);

    // asynchronous reset mid-stream
    resetN = 1'b0;
    #1;
    check("arst_red", red_o, 8'h00);
    check("arst_blue", blue_o, 8'h00);
    tick();
    resetN = 1'b1;
    tick();

    // disable layer 0 mid-frame: takes effect only at next frame start
    bg  = 8'h00;
    req = 6'b001001;
    pulse_sof();
    cfg_valid = 1'b1;
    cfg_layer = 3'd0;
    cfg_en    = 1'b0;
    tick();
    cfg_valid = 1'b0;
    tick();
    tick();
    check("midframe_red", red_o, 8'hFF);
    check("midframe_green", green_o, 8'h00);
    pulse_sof();
    tick();
    tick();
    check("nextframe_red", red_o, 8'h00);
    check("nextframe_green", green_o, 8'hFF);

    // cfgValid across frame start, repeated writes, out-of-range index
    cfg_valid = 1'b1;
    cfg_layer = 3'd0;
    cfg_en    = 1'b1;
    sof       = 1'b1;
    #1;
    check("sof_ready", cfg_ready, 0);
    tick();
    sof = 1'b0;
    #1;
    check("post_sof_ready", cfg_ready, 1);
    tick();
    cfg_en = 1'b0;
    tick();
    cfg_en = 1'b1;
    tick();
    cfg_layer = 3'd6;
    cfg_en    = 1'b0;
    tick();
    cfg_layer = 3'd7;
    tick();
    cfg_valid = 1'b0;
    check("still_hidden_green", green_o, 8'hFF);
    pulse_sof();
    tick();
    tick();
    check("last_write_red", red_o, 8'hFF);
    check("last_write_green", green_o, 8'h00);

    // blink with BLINK_LOG2=1: two frames shown, two hidden
    do_reset();
    req       = 6'b001001;
    cfg_valid = 1'b1;
    cfg_layer = 3'd0;
    cfg_en    = 1'b1;
    cfg_blink = 1'b1;
    tick();
    cfg_valid = 1'b0;
    cfg_blink = 1'b0;
    for (int f = 1; f <= 7; f++) begin
      pulse_sof();
      tick();
      tick();
      vis = ((f % 4) == 0) || ((f % 4) == 1);
      check($sformatf("blink_red_f%0d", f), red_o, vis ? 8'hFF : 8'h00);
      check($sformatf("blink_green_f%0d", f), green_o, vis ? 8'h00 : 8'hFF);
    end

    // collision: layers 1 and 2 overlap for one pixel, then a clean frame
    do_reset();
    req = '0;
    pulse_sof();
    req = 6'b000110;
    tick();
    req = 6'b000010;
    repeat (3) tick();
    req = '0;
    pulse_sof();
`ifdef LAYER_COLLISION_DETECT_EN
    check("coll_mask", coll_mask, 6'b000110);
    check("coll_flag", coll_flag, 1);
`else
    check("coll_mask", coll_mask, 0);
    check("coll_flag", coll_flag, 0);
`endif
    req = 6'b000001;
    repeat (3) tick();
    req = '0;
    pulse_sof();
    check("clean_mask", coll_mask, 0);
    check("clean_flag", coll_flag, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
